// File: rtl/rob_commit.sv
// In-order retirement buffer: dual-slot allocation from rename, writeback completion, dual in-order commit.
// Optional synchronous flush port is enabled by defining ROB_FLUSH_EN.
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 4,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
`ifdef ROB_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              v1,
    input  logic              v2,
    input  logic              hasdst1,
    input  logic              hasdst2,
    input  logic [PREG_W-1:0] oldpr1,
    input  logic [PREG_W-1:0] oldpr2,
    output logic [TAG_W-1:0]  tag1,
    output logic [TAG_W-1:0]  tag2,
    output logic              alloc_stall,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    output logic [1:0]        cmtcnt,
    output logic              free1_v,
    output logic [PREG_W-1:0] free1_pr,
    output logic              free2_v,
    output logic [PREG_W-1:0] free2_pr,
    output logic              empty
);

    localparam logic [TAG_W-1:0] PTR_ONE     = TAG_W'(1);
    localparam logic [TAG_W:0]   STALL_LEVEL = (TAG_W+1)'(DEPTH - 1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  hasdst_q;
    logic [PREG_W-1:0] oldpr_q [DEPTH];

    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic [TAG_W-1:0]  head_nx1;
    logic [TAG_W-1:0]  tail_nx1;
    logic              c0;
    logic              c1;
    logic [1:0]        ncmt;
    logic              acc1;
    logic              acc2;
    logic [1:0]        nalloc;
    logic              wb_hit;
    logic              flush_now;

`ifdef ROB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Commit looks only at the registered state, so a writeback never retires on its own edge.
    always_comb begin
        head_nx1    = head_q + PTR_ONE;
        tail_nx1    = tail_q + PTR_ONE;
        c0          = valid_q[head_q] & done_q[head_q];
        c1          = c0 & valid_q[head_nx1] & done_q[head_nx1];
        ncmt        = {1'b0, c0} + {1'b0, c1};
        alloc_stall = (count_q >= STALL_LEVEL);
        acc1        = v1 & ~alloc_stall;
        acc2        = acc1 & v2;
        nalloc      = {1'b0, acc1} + {1'b0, acc2};
        wb_hit      = wb_valid & valid_q[wb_tag];
        empty       = (count_q == '0);
        tag1        = tail_q;
        tag2        = tail_nx1;
    end

    // Allocated slots are always free entries, so they never collide with the retiring ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cmtcnt   <= '0;
            free1_v  <= 1'b0;
            free2_v  <= 1'b0;
            free1_pr <= '0;
            free2_pr <= '0;
        end else if (flush_now) begin
            valid_q  <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cmtcnt   <= '0;
            free1_v  <= 1'b0;
            free2_v  <= 1'b0;
        end else begin
            if (wb_hit) begin
                done_q[wb_tag] <= 1'b1;
            end
            if (c0) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                free1_pr        <= oldpr_q[head_q];
            end
            if (c1) begin
                valid_q[head_nx1] <= 1'b0;
                done_q[head_nx1]  <= 1'b0;
                free2_pr          <= oldpr_q[head_nx1];
            end
            if (acc1) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
            end
            if (acc2) begin
                valid_q[tail_nx1] <= 1'b1;
                done_q[tail_nx1]  <= 1'b0;
            end
            head_q  <= head_q + TAG_W'(ncmt);
            tail_q  <= tail_q + TAG_W'(nalloc);
            count_q <= count_q + (TAG_W+1)'(nalloc) - (TAG_W+1)'(ncmt);
            cmtcnt  <= ncmt;
            free1_v <= c0 & hasdst_q[head_q];
            free2_v <= c1 & hasdst_q[head_nx1];
        end
    end

    // Payload needs no reset: it is only read while the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (acc1) begin
            hasdst_q[tail_q] <= hasdst1;
            oldpr_q[tail_q]  <= oldpr1;
        end
        if (acc2) begin
            hasdst_q[tail_nx1] <= hasdst2;
            oldpr_q[tail_nx1]  <= oldpr2;
        end
    end

endmodule
